mips_cpu_regfile_sb: RTL and testbench
======================================

Name: mips_cpu_regfile_sb

Overview:
Parametrised successor to the CPU general-purpose register file for the multi-cycle/pipelined datapath. It provides:
- two combinational read ports;
- two synchronous write ports (ALU writeback and load/HI-LO writeback);
- a per-register busy scoreboard, so the control unit can stall on registers with an outstanding multi-cycle producer (loads, MULT/DIV results moved to GPRs).

Register 0 is hardwired to zero. A debug tap for $v0 is kept for the testbench.

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 5, register address width; number of registers NUM_REGS = 2**ADDR_W
V0_IDX, 2, index driven onto register_v0 debug output

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
wr_en_a  input  1  write enable, port A (ALU writeback)
wr_addr_a  input  ADDR_W  write address, port A
wr_data_a  input  DATA_W  write data, port A
wr_en_b  input  1  write enable, port B (load/late writeback)
wr_addr_b  input  ADDR_W  write address, port B
wr_data_b  input  DATA_W  write data, port B
issue_en  input  1  mark issue_addr busy (multi-cycle producer issued)
issue_addr  input  ADDR_W  register to mark busy
rd_addr_a  input  ADDR_W  read address A
rd_data_a  output  DATA_W  read data A
rd_busy_a  output  1  register at rd_addr_a has pending producer
rd_addr_b  input  ADDR_W  read address B
rd_data_b  output  DATA_W  read data B
rd_busy_b  output  1  register at rd_addr_b has pending producer
busy_any  output  1  OR of all busy bits
register_v0  output  DATA_W  current contents of register V0_IDX

Behaviour:
- Reset (sampled on posedge clk, reset=1):
  - all registers are 0 and all busy bits are 0 after the edge;
  - while reset=1, rd_data_a/b=0, rd_busy_a/b=0 and busy_any=0, regardless of address;
  - register_v0 reflects storage, so it is 0 from the first edge after reset is asserted.
- Reset mid-operation: reset overrides any write or issue in the same cycle. Pending busy bits are discarded.
- Reads: combinatorial from storage; zero latency.
- Writes: take effect at posedge clk. New data is visible on the read ports the cycle after the edge (unless the bypass feature is enabled).
- Register 0: writes to address 0 on either port are ignored. Reads of address 0 always return 0. The busy bit for address 0 is never set; issue_addr=0 is a no-op.
- Same-cycle writes, both ports, same nonzero address: port B wins (its data is stored); port A's write is dropped. Different addresses: both writes happen.
- Scoreboard, per register r (nonzero):
  - set: issue_en && issue_addr==r;
  - clear: (wr_en_a && wr_addr_a==r) || (wr_en_b && wr_addr_b==r);
  - set and clear in the same cycle: set wins, so busy stays/becomes 1 (new producer supersedes the retiring one);
  - otherwise the bit holds.
- Busy outputs: rd_busy_a/b are combinational lookups of the busy bits (address 0 gives 0). busy_any is combinational OR over all busy bits.
- Issue to an already-busy register: no error; it stays busy and is cleared by the next write to it.
- Write to a non-busy register: a normal write; the busy bit stays 0.
- Widths: no arithmetic. All data is passed through unmodified at DATA_W.

Optional Feature:
MIPS_CPU_REGFILE_BYPASS_EN
- Defined:
  - When rd_addr_x matches a write port's address with that enable high and a nonzero address, rd_data_x returns that write data in the same cycle. Port B has priority over port A.
  - rd_busy_x returns 0 when rd_addr_x matches an active write, unless issue_en targets that same address this cycle.
  - Reset still forces all read outputs to 0.
- Not defined: reads return the stored (pre-edge) value only; no forwarding logic is present.

Test Plan:
- Reset then read: assert reset 1 cycle, deassert -> rd_data_a/b=0 for every address 0..31, busy_any=0, register_v0=0.
- Write/read with r0 protection: wr_en_a=1, wr_addr_a=2, wr_data_a=0xDEADBEEF; next cycle write 0x12345678 to address 0 -> register_v0=0xDEADBEEF; rd_addr_a=2 gives 0xDEADBEEF; rd_addr_b=0 gives 0.
- Port collision: same cycle write A(5, 0x11111111) and B(5, 0x22222222) -> next cycle rd_addr_a=5 returns 0x22222222. Different addresses A(6, 0xA), B(7, 0xB) -> both stored.
- Scoreboard: issue_en addr 8 -> next cycle rd_busy_a=1 at addr 8, busy_any=1; wr_en_b addr 8 data 0x55 -> next cycle busy 0 and data 0x55. In the same cycle, issue addr 9 plus write addr 9 -> busy 9 = 1.
- Reset mid-flight: registers 8 and 9 busy, reg 3=0x77; assert reset together with wr_en_a addr 3 data 0x99 -> after the edge all busy=0, reg 3=0, reads 0.
- Bypass (macro defined): wr_en_a addr 4 data 0xCAFEF00D with rd_addr_a=4 in the same cycle -> rd_data_a=0xCAFEF00D that cycle. Without the macro -> the old value (0 after reset).

Source files
------------

// File: rtl/mips_cpu_regfile_sb.sv
// Register file, two read / two write ports, with a per-register busy scoreboard.
// Define MIPS_CPU_REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module mips_cpu_regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int V0_IDX = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_a,
    input  logic [ADDR_W-1:0] wr_addr_a,
    input  logic [DATA_W-1:0] wr_data_a,
    input  logic              wr_en_b,
    input  logic [ADDR_W-1:0] wr_addr_b,
    input  logic [DATA_W-1:0] wr_data_b,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_busy_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_b,
    output logic              busy_any,
    output logic [DATA_W-1:0] register_v0
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            regs[0] <= '0;
            busy[0] <= 1'b0;
            for (int r = 1; r < NUM_REGS; r++) begin
                // Port B is the later producer, so it wins a same-address collision.
                if (wr_en_b && wr_addr_b == ADDR_W'(r)) begin
                    regs[r] <= wr_data_b;
                end else if (wr_en_a && wr_addr_a == ADDR_W'(r)) begin
                    regs[r] <= wr_data_a;
                end
                if (issue_en && issue_addr == ADDR_W'(r)) begin
                    busy[r] <= 1'b1;
                end else if ((wr_en_a && wr_addr_a == ADDR_W'(r)) ||
                             (wr_en_b && wr_addr_b == ADDR_W'(r))) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        rd_busy_a = 1'b0;
        rd_busy_b = 1'b0;
        busy_any  = 1'b0;
        if (!reset) begin
            busy_any = |busy;
            if (rd_addr_a != '0) begin
                rd_data_a = regs[rd_addr_a];
                rd_busy_a = busy[rd_addr_a];
`ifdef MIPS_CPU_REGFILE_BYPASS_EN
                if (wr_en_b && wr_addr_b == rd_addr_a) begin
                    rd_data_a = wr_data_b;
                end else if (wr_en_a && wr_addr_a == rd_addr_a) begin
                    rd_data_a = wr_data_a;
                end
                if (((wr_en_a && wr_addr_a == rd_addr_a) ||
                     (wr_en_b && wr_addr_b == rd_addr_a)) &&
                    !(issue_en && issue_addr == rd_addr_a)) begin
                    rd_busy_a = 1'b0;
                end
`endif
            end
            if (rd_addr_b != '0) begin
                rd_data_b = regs[rd_addr_b];
                rd_busy_b = busy[rd_addr_b];
`ifdef MIPS_CPU_REGFILE_BYPASS_EN
                if (wr_en_b && wr_addr_b == rd_addr_b) begin
                    rd_data_b = wr_data_b;
                end else if (wr_en_a && wr_addr_a == rd_addr_b) begin
                    rd_data_b = wr_data_a;
                end
                if (((wr_en_a && wr_addr_a == rd_addr_b) ||
                     (wr_en_b && wr_addr_b == rd_addr_b)) &&
                    !(issue_en && issue_addr == rd_addr_b)) begin
                    rd_busy_b = 1'b0;
                end
`endif
            end
        end
    end

    assign register_v0 = regs[V0_IDX];

endmodule

// File: tb/tb_mips_cpu_regfile_sb.sv
// Self-checking bench for mips_cpu_regfile_sb: directed table, corner sequences,
// and randomized traffic checked against an array-based reference model.
module tb_mips_cpu_regfile_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en_a, wr_en_b, issue_en;
    logic [4:0]  wr_addr_a, wr_addr_b, issue_addr, rd_addr_a, rd_addr_b;
    logic [31:0] wr_data_a, wr_data_b;
    logic [31:0] rd_data_a, rd_data_b, register_v0;
    logic        rd_busy_a, rd_busy_b, busy_any;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [32];
    logic        bsy [32];

    always #5 clk = ~clk;

    mips_cpu_regfile_sb #(.DATA_W(32), .ADDR_W(5), .V0_IDX(2)) dut (
        .clk(clk), .reset(reset),
        .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
        .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_busy_a(rd_busy_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_busy_b(rd_busy_b),
        .busy_any(busy_any), .register_v0(register_v0)
    );

    typedef struct {
        logic        wa_en;
        logic [4:0]  wa_addr;
        logic [31:0] wa_data;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        is_en;
        logic [4:0]  is_addr;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_busy_a;
        logic        exp_any;
        logic [31:0] exp_v0;
    } vec_t;

    vec_t tbl [8];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (reset || a == 5'd0) return 32'h0;
`ifdef MIPS_CPU_REGFILE_BYPASS_EN
        if (wr_en_b && wr_addr_b == a) return wr_data_b;
        if (wr_en_a && wr_addr_a == a) return wr_data_a;
`endif
        return mem[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        if (reset || a == 5'd0) return 1'b0;
`ifdef MIPS_CPU_REGFILE_BYPASS_EN
        if (((wr_en_a && wr_addr_a == a) || (wr_en_b && wr_addr_b == a)) &&
            !(issue_en && issue_addr == a)) return 1'b0;
`endif
        return bsy[a];
    endfunction

    function automatic logic m_any();
        logic r = 1'b0;
        if (reset) return 1'b0;
        for (int i = 0; i < 32; i++) r = r | bsy[i];
        return r;
    endfunction

    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] = 32'h0;
                bsy[i] = 1'b0;
            end
        end else begin
            if (wr_en_a && wr_addr_a != 5'd0) begin
                mem[wr_addr_a] = wr_data_a;
                bsy[wr_addr_a] = 1'b0;
            end
            if (wr_en_b && wr_addr_b != 5'd0) begin
                mem[wr_addr_b] = wr_data_b;
                bsy[wr_addr_b] = 1'b0;
            end
            if (issue_en && issue_addr != 5'd0) bsy[issue_addr] = 1'b1;
        end
    endtask

    task automatic check_model();
        cmp("model rd_data_a", rd_data_a, m_rd(rd_addr_a));
        cmp("model rd_data_b", rd_data_b, m_rd(rd_addr_b));
        cmp("model rd_busy_a", {31'h0, rd_busy_a}, {31'h0, m_busy(rd_addr_a)});
        cmp("model rd_busy_b", {31'h0, rd_busy_b}, {31'h0, m_busy(rd_addr_b)});
        cmp("model busy_any", {31'h0, busy_any}, {31'h0, m_any()});
        cmp("model register_v0", register_v0, mem[2]);
    endtask

    task automatic idle();
        reset = 1'b0;
        wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
        wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
        issue_en = 1'b0; issue_addr = '0;
        rd_addr_a = '0; rd_addr_b = '0;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic vec_t mk(input logic wae, input logic [4:0] waa, input logic [31:0] wad,
                                input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
                                input logic ie, input logic [4:0] ia,
                                input logic [4:0] ra, input logic [4:0] rb,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic eba, input logic eany, input logic [31:0] ev0);
        vec_t v;
        v.wa_en = wae; v.wa_addr = waa; v.wa_data = wad;
        v.wb_en = wbe; v.wb_addr = wba; v.wb_data = wbd;
        v.is_en = ie;  v.is_addr = ia;
        v.ra = ra; v.rb = rb;
        v.exp_a = ea; v.exp_b = eb; v.exp_busy_a = eba; v.exp_any = eany; v.exp_v0 = ev0;
        return v;
    endfunction

    initial begin
        tbl[0] = mk(1, 2, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[1] = mk(1, 0, 32'h12345678, 0, 0, 0, 0, 0, 2, 0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF);
        tbl[2] = mk(1, 5, 32'h11111111, 1, 5, 32'h22222222, 0, 0, 2, 0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF);
        tbl[3] = mk(1, 6, 32'hA, 1, 7, 32'hB, 0, 0, 5, 0, 32'h22222222, 0, 0, 0, 32'hDEADBEEF);
        tbl[4] = mk(0, 0, 0, 0, 0, 0, 1, 8, 6, 7, 32'hA, 32'hB, 0, 0, 32'hDEADBEEF);
`ifdef MIPS_CPU_REGFILE_BYPASS_EN
        tbl[5] = mk(0, 0, 0, 1, 8, 32'h55, 0, 0, 8, 5, 32'h55, 32'h22222222, 0, 1, 32'hDEADBEEF);
        tbl[6] = mk(1, 9, 32'h99, 0, 0, 0, 1, 9, 8, 9, 32'h55, 32'h99, 0, 0, 32'hDEADBEEF);
`else
        tbl[5] = mk(0, 0, 0, 1, 8, 32'h55, 0, 0, 8, 5, 32'h0, 32'h22222222, 1, 1, 32'hDEADBEEF);
        tbl[6] = mk(1, 9, 32'h99, 0, 0, 0, 1, 9, 8, 9, 32'h55, 32'h0, 0, 0, 32'hDEADBEEF);
`endif
        tbl[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 8, 32'h99, 32'h55, 1, 1, 32'hDEADBEEF);

        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'h0;
            bsy[i] = 1'b0;
        end

        // Initial reset, then sweep every address.
        idle();
        reset = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        cmp("reset rd_data_a", rd_data_a, 32'h0);
        cmp("reset busy_any", {31'h0, busy_any}, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            cmp("post-reset rd_data_a", rd_data_a, 32'h0);
            cmp("post-reset rd_data_b", rd_data_b, 32'h0);
        end
        cmp("post-reset busy_any", {31'h0, busy_any}, 32'h0);
        cmp("post-reset register_v0", register_v0, 32'h0);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            wr_en_a = tbl[i].wa_en; wr_addr_a = tbl[i].wa_addr; wr_data_a = tbl[i].wa_data;
            wr_en_b = tbl[i].wb_en; wr_addr_b = tbl[i].wb_addr; wr_data_b = tbl[i].wb_data;
            issue_en = tbl[i].is_en; issue_addr = tbl[i].is_addr;
            rd_addr_a = tbl[i].ra; rd_addr_b = tbl[i].rb;
            @(negedge clk);
            check_model();
            cmp($sformatf("tbl%0d rd_data_a", i), rd_data_a, tbl[i].exp_a);
            cmp($sformatf("tbl%0d rd_data_b", i), rd_data_b, tbl[i].exp_b);
            cmp($sformatf("tbl%0d rd_busy_a", i), {31'h0, rd_busy_a}, {31'h0, tbl[i].exp_busy_a});
            cmp($sformatf("tbl%0d busy_any", i), {31'h0, busy_any}, {31'h0, tbl[i].exp_any});
            cmp($sformatf("tbl%0d register_v0", i), register_v0, tbl[i].exp_v0);
            @(posedge clk);
            model_edge();
            #1;
        end

        // Reset mid-flight: 8 and 9 busy, reg 3 holds 0x77.
        idle();
        issue_en = 1'b1; issue_addr = 5'd8;
        wr_en_a = 1'b1; wr_addr_a = 5'd3; wr_data_a = 32'h77;
        cycle();
        idle();
        rd_addr_a = 5'd8; rd_addr_b = 5'd9;
        #1;
        cmp("midflight busy8", {31'h0, rd_busy_a}, 32'h1);
        cmp("midflight busy9", {31'h0, rd_busy_b}, 32'h1);
        reset = 1'b1;
        wr_en_a = 1'b1; wr_addr_a = 5'd3; wr_data_a = 32'h99;
        rd_addr_a = 5'd3;
        cycle();
        cmp("midflight v0 cleared", register_v0, 32'h0);
        idle();
        rd_addr_a = 5'd3; rd_addr_b = 5'd8;
        #1;
        cmp("midflight reg3", rd_data_a, 32'h0);
        cmp("midflight busy8 cleared", {31'h0, rd_busy_b}, 32'h0);
        cmp("midflight busy_any", {31'h0, busy_any}, 32'h0);

        // Same-cycle write/read of reg 4.
        wr_en_a = 1'b1; wr_addr_a = 5'd4; wr_data_a = 32'hCAFEF00D;
        rd_addr_a = 5'd4;
        #1;
`ifdef MIPS_CPU_REGFILE_BYPASS_EN
        cmp("bypass rd_data_a", rd_data_a, 32'hCAFEF00D);
`else
        cmp("no-bypass rd_data_a", rd_data_a, 32'h0);
`endif
        cycle();
        idle();
        rd_addr_a = 5'd4;
        #1;
        cmp("reg4 after write", rd_data_a, 32'hCAFEF00D);

        // Randomized traffic on a narrowed address range to force collisions.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            wr_en_a = 1'($urandom_range(0, 1));
            wr_addr_a = 5'($urandom_range(0, 7));
            wr_data_a = $urandom;
            wr_en_b = 1'($urandom_range(0, 1));
            wr_addr_b = 5'($urandom_range(0, 7));
            wr_data_b = $urandom;
            issue_en = 1'($urandom_range(0, 1));
            issue_addr = 5'($urandom_range(0, 7));
            rd_addr_a = 5'($urandom_range(0, 8));
            rd_addr_b = 5'($urandom_range(0, 31));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
